// File: rtl/bhg_line_fetch_pkg.sv
// rtl/bhg_line_fetch_pkg.sv - shared types and constants for the display line-fetch DMA
package bhg_line_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam int WORD_BYTES = 16;
    localparam int WB_SHIFT   = 4;
    localparam int LBUF_AW    = 10;
    // Word counters must hold H_WORDS itself (up to 512).
    localparam int CNT_W      = 10;

endpackage

// File: rtl/bhg_fetch_addr_gen.sv
// rtl/bhg_fetch_addr_gen.sv - line/word address accumulators and issue/return counters
module bhg_fetch_addr_gen
    import bhg_line_fetch_pkg::*;
#(
    parameter int ADDR_SIZE  = 29,
    parameter int H_WORDS    = 480,
    parameter int BASE_ADDR  = 0,
    parameter int LINE_PITCH = 8192,
    parameter int MAX_OUTST  = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 frame_init_i,
    input  logic [8:0]           scroll_word_i,
    input  logic                 line_adv_i,
    input  logic                 fetch_start_i,
    input  logic                 accept_i,
    input  logic                 ret_i,
    output logic [ADDR_SIZE-1:0] word_addr_o,
    output logic [8:0]           ret_cnt_o,
    output logic                 iss_done_o,
    output logic                 ret_done_o,
    output logic                 drained_o,
    output logic                 can_issue_o
);

    localparam logic [CNT_W-1:0]     H_W     = CNT_W'(H_WORDS);
    localparam logic [CNT_W-1:0]     MAX_W   = CNT_W'(MAX_OUTST);
    localparam logic [ADDR_SIZE-1:0] BASE_A  = ADDR_SIZE'(BASE_ADDR);
    localparam logic [ADDR_SIZE-1:0] PITCH_A = ADDR_SIZE'(LINE_PITCH);
    localparam logic [ADDR_SIZE-1:0] STEP_A  = ADDR_SIZE'(WORD_BYTES);

    logic [ADDR_SIZE-1:0] line_addr_q, line_addr_d;
    logic [ADDR_SIZE-1:0] word_addr_q, word_addr_d;
    logic [CNT_W-1:0]     iss_q, iss_d, ret_q, ret_d, outst_d;

    always_comb begin
        iss_d   = fetch_start_i ? '0 : iss_q + CNT_W'(accept_i);
        ret_d   = fetch_start_i ? '0 : ret_q + CNT_W'(ret_i);
        outst_d = iss_d - ret_d;

        line_addr_d = line_addr_q;
        if (frame_init_i) begin
            line_addr_d = BASE_A + (ADDR_SIZE'(scroll_word_i) << WB_SHIFT);
        end else if (line_adv_i) begin
            line_addr_d = line_addr_q + PITCH_A;
        end

        word_addr_d = word_addr_q;
        if (fetch_start_i) begin
            word_addr_d = line_addr_q;
        end else if (accept_i) begin
            word_addr_d = word_addr_q + STEP_A;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            line_addr_q <= BASE_A;
            word_addr_q <= '0;
            iss_q       <= '0;
            ret_q       <= '0;
        end else begin
            line_addr_q <= line_addr_d;
            word_addr_q <= word_addr_d;
            iss_q       <= iss_d;
            ret_q       <= ret_d;
        end
    end

    // Flags look at next-state counts so the FSM can act on the edge that reaches them.
    assign word_addr_o = word_addr_q;
    assign ret_cnt_o   = ret_q[8:0];
    assign iss_done_o  = (iss_d == H_W);
    assign ret_done_o  = (ret_d == H_W);
    assign drained_o   = (ret_d == iss_d);
    assign can_issue_o = (iss_d < H_W) && (outst_d < MAX_W);

endmodule

// File: rtl/bhg_line_fetch.sv
// rtl/bhg_line_fetch.sv - display line-fetch DMA: one DDR3 line per H-sync into a 2-line buffer
module bhg_line_fetch
    import bhg_line_fetch_pkg::*;
#(
    parameter int ADDR_SIZE  = 29,
    parameter int H_WORDS    = 480,
    parameter int V_LINES    = 1080,
    parameter int BASE_ADDR  = 0,
    parameter int LINE_PITCH = 8192,
    parameter int MAX_OUTST  = 16
) (
    input  logic                 CMD_CLK,
    input  logic                 reset,
    input  logic [10:0]          scroll_x,
    input  logic                 CMD_xena_out,
    input  logic                 CMD_yena_out,
    output logic [1:0]           CMD_xpos_in,
    output logic                 CMD_ypos_in,
    output logic                 CMD_line_mem_wena,
    output logic [LBUF_AW-1:0]   CMD_line_mem_waddr,
    output logic [127:0]         CMD_line_mem_wdata,
    input  logic                 CMD_busy,
    output logic                 CMD_ena,
    output logic                 CMD_write_ena,
    output logic [ADDR_SIZE-1:0] CMD_addr,
    input  logic                 CMD_read_ready,
    input  logic [127:0]         CMD_read_data,
    output logic                 underrun,
    output logic                 frame_start
);

    localparam int                LINE_W = $clog2(V_LINES + 1);
    localparam logic [LINE_W-1:0] V_L    = LINE_W'(V_LINES);

    fetch_state_t       state_q;
    logic               xena_q, yena_q, armed_q, abort_q, disp_buf_q, filled_q;
    logic               ena_q, wena_q, frame_start_q, underrun_q;
    logic [1:0]         xpos_q;
    logic [LINE_W-1:0]  line_q;
    logic [LBUF_AW-1:0] waddr_q;
    logic [127:0]       wdata_q;

    logic       xfall, yfall, accept, ret_hit, complete, filled_eff, fetch_start, line_adv;
    logic [8:0] ret_cnt;
    logic       iss_done, ret_done, drained, can_issue;

    assign xfall       = xena_q & ~CMD_xena_out;
    assign yfall       = yena_q & ~CMD_yena_out;
    assign accept      = ena_q & ~CMD_busy;
    assign ret_hit     = CMD_read_ready & (state_q != ST_IDLE);
    assign complete    = (state_q == ST_DRAIN) & ~abort_q & ret_done;
    assign filled_eff  = filled_q | complete;
    // Nothing is fetched until a frame start has supplied the scroll origin.
    assign fetch_start = (state_q == ST_IDLE) & armed_q & ~filled_q & (line_q < V_L) & ~yfall;
    assign line_adv    = complete & ~yfall;

    bhg_fetch_addr_gen #(
        .ADDR_SIZE  (ADDR_SIZE),
        .H_WORDS    (H_WORDS),
        .BASE_ADDR  (BASE_ADDR),
        .LINE_PITCH (LINE_PITCH),
        .MAX_OUTST  (MAX_OUTST)
    ) u_addr_gen (
        .clk_i         (CMD_CLK),
        .reset_i       (reset),
        .frame_init_i  (yfall),
        .scroll_word_i (scroll_x[10:2]),
        .line_adv_i    (line_adv),
        .fetch_start_i (fetch_start),
        .accept_i      (accept),
        .ret_i         (ret_hit),
        .word_addr_o   (CMD_addr),
        .ret_cnt_o     (ret_cnt),
        .iss_done_o    (iss_done),
        .ret_done_o    (ret_done),
        .drained_o     (drained),
        .can_issue_o   (can_issue)
    );

    always_ff @(posedge CMD_CLK) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            xena_q        <= 1'b0;
            yena_q        <= 1'b0;
            armed_q       <= 1'b0;
            abort_q       <= 1'b0;
            disp_buf_q    <= 1'b0;
            filled_q      <= 1'b0;
            ena_q         <= 1'b0;
            wena_q        <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            xpos_q        <= '0;
            line_q        <= '0;
            waddr_q       <= '0;
            wdata_q       <= '0;
        end else begin
            xena_q        <= CMD_xena_out;
            yena_q        <= CMD_yena_out;
            frame_start_q <= yfall;
            underrun_q    <= xfall & ~yfall & ~filled_eff;
            wena_q        <= ret_hit & ~abort_q & ~yfall;
            waddr_q       <= {~disp_buf_q, ret_cnt};
            wdata_q       <= CMD_read_data;

            if (yfall) begin
                armed_q    <= 1'b1;
                line_q     <= '0;
                xpos_q     <= scroll_x[1:0];
                disp_buf_q <= 1'b1;
                filled_q   <= 1'b0;
                ena_q      <= 1'b0;
                // An interrupted fetch must swallow its in-flight returns before line 0 starts.
                if (state_q != ST_IDLE && !drained) begin
                    state_q <= ST_DRAIN;
                    abort_q <= 1'b1;
                end else begin
                    state_q <= ST_IDLE;
                    abort_q <= 1'b0;
                end
            end else begin
                if (xfall && filled_eff) begin
                    disp_buf_q <= ~disp_buf_q;
                    filled_q   <= 1'b0;
                end else if (complete) begin
                    filled_q <= 1'b1;
                end
                if (line_adv) begin
                    line_q <= line_q + LINE_W'(1);
                end

                unique case (state_q)
                    ST_IDLE: begin
                        if (fetch_start) begin
                            state_q <= ST_REQ;
                            ena_q   <= 1'b1;
                        end
                    end
                    ST_REQ: begin
                        if (iss_done) begin
                            state_q <= ST_DRAIN;
                            ena_q   <= 1'b0;
                        end else begin
                            ena_q <= can_issue;
                        end
                    end
                    ST_DRAIN: begin
                        if (abort_q ? drained : ret_done) begin
                            state_q <= ST_IDLE;
                            abort_q <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign CMD_xpos_in        = xpos_q;
    assign CMD_ypos_in        = disp_buf_q;
    assign CMD_line_mem_wena  = wena_q;
    assign CMD_line_mem_waddr = waddr_q;
    assign CMD_line_mem_wdata = wdata_q;
    assign CMD_ena            = ena_q;
    assign CMD_write_ena      = 1'b0;
    assign underrun           = underrun_q;
    assign frame_start        = frame_start_q;

endmodule

// File: tb/tb_bhg_line_fetch.sv
// tb/tb_bhg_line_fetch.sv - self-checking bench for bhg_line_fetch with an in-order DDR3 read model
module tb_bhg_line_fetch;

    localparam int AS    = 29;
    localparam int HW    = 8;
    localparam int VL    = 4;
    localparam int BASE  = 32'h1000;
    localparam int PITCH = 256;
    localparam int MO    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [10:0]   scroll_x = '0;
    logic          xena = 1'b0, yena = 1'b0, busy = 1'b0;
    logic          read_ready = 1'b0;
    logic [127:0]  read_data = '0;
    logic [1:0]    xpos;
    logic          ypos, wena, cmd_ena, write_ena, underrun, frame_start;
    logic [9:0]    waddr;
    logic [127:0]  wdata;
    logic [AS-1:0] cmd_addr;

    always #5 clk = ~clk;

    bhg_line_fetch #(
        .ADDR_SIZE(AS), .H_WORDS(HW), .V_LINES(VL),
        .BASE_ADDR(BASE), .LINE_PITCH(PITCH), .MAX_OUTST(MO)
    ) dut (
        .CMD_CLK            (clk),
        .reset              (reset),
        .scroll_x           (scroll_x),
        .CMD_xena_out       (xena),
        .CMD_yena_out       (yena),
        .CMD_xpos_in        (xpos),
        .CMD_ypos_in        (ypos),
        .CMD_line_mem_wena  (wena),
        .CMD_line_mem_waddr (waddr),
        .CMD_line_mem_wdata (wdata),
        .CMD_busy           (busy),
        .CMD_ena            (cmd_ena),
        .CMD_write_ena      (write_ena),
        .CMD_addr           (cmd_addr),
        .CMD_read_ready     (read_ready),
        .CMD_read_data      (read_data),
        .underrun           (underrun),
        .frame_start        (frame_start)
    );

    int total = 0;
    int bad   = 0;
    int lat   = 6;
    int cycle = 0;
    int fs_cnt = 0, ur_cnt = 0, max_out = 0;
    logic [AS-1:0]  acc_q[$];
    logic [AS-1:0]  pend_q[$];
    int             due_q[$];
    logic [137:0]   wr_q[$];

    function automatic logic [127:0] fdata(input logic [AS-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        return {w ^ 32'hDEADBEEF, w, ~w, w + 32'd1};
    endfunction

    // DDR3 read port model and output monitor; samples on the falling edge.
    always @(negedge clk) begin
        cycle++;
        if (!reset && cmd_ena && !busy) begin
            acc_q.push_back(cmd_addr);
            pend_q.push_back(cmd_addr);
            due_q.push_back(cycle + lat);
        end
        if (wena) wr_q.push_back({waddr, wdata});
        if (frame_start) fs_cnt++;
        if (underrun) ur_cnt++;
        if (pend_q.size() > 0 && due_q[0] <= cycle) begin
            read_ready = 1'b1;
            read_data  = fdata(pend_q[0]);
            void'(pend_q.pop_front());
            void'(due_q.pop_front());
        end else begin
            read_ready = 1'b0;
            read_data  = '0;
        end
        if (pend_q.size() > max_out) max_out = pend_q.size();
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_xfall();
        xena = 1'b1; cyc();
        xena = 1'b0; cyc();
    endtask

    task automatic do_yfall();
        yena = 1'b1; cyc();
        yena = 1'b0; cyc();
    endtask

    task automatic wait_writes(input string tag, input int bw, input int budget);
        int k;
        k = 0;
        while (wr_q.size() - bw < HW && k < budget) begin
            cyc();
            k++;
        end
        check({tag, "_wait"}, 160'(wr_q.size() - bw >= HW), 160'(1));
    endtask

    task automatic check_fetch(input string tag, input int ba, input int bw,
                               input logic [AS-1:0] a0, input bit b);
        logic [AS-1:0]  ea, ga;
        logic [137:0]   gw;
        check({tag, "_nacc"}, 160'(acc_q.size() - ba), 160'(HW));
        for (int i = 0; i < HW; i++) begin
            ea = a0 + AS'(16 * i);
            ga = (ba + i < acc_q.size()) ? acc_q[ba + i] : 'x;
            gw = (bw + i < wr_q.size()) ? wr_q[bw + i] : 'x;
            check($sformatf("%s_addr%0d", tag, i), 160'(ga), 160'(ea));
            check($sformatf("%s_waddr%0d", tag, i), 160'(gw[137:128]), 160'({b, 9'(i)}));
            check($sformatf("%s_wdata%0d", tag, i), 160'(gw[127:0]), 160'(fdata(ea)));
        end
    endtask

    typedef struct {
        bit            yev;
        logic [10:0]   scroll;
        int            lat;
        int            busy_len;
        bit            fetch;
        logic [AS-1:0] addr0;
        bit            buf_sel;
        bit            ypos;
        logic [1:0]    xpos;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int ba, bw, k;
        logic [AS-1:0] held;
        bit stable;

        vecs[0] = '{1'b1, 11'd5,  6, 0,  1'b1, 29'h1010, 1'b0, 1'b1, 2'd1};
        vecs[1] = '{1'b0, 11'd5,  6, 0,  1'b1, 29'h1110, 1'b1, 1'b0, 2'd1};
        vecs[2] = '{1'b0, 11'd5,  6, 10, 1'b1, 29'h1210, 1'b0, 1'b1, 2'd1};
        vecs[3] = '{1'b0, 11'd5,  3, 0,  1'b1, 29'h1310, 1'b1, 1'b0, 2'd1};
        vecs[4] = '{1'b0, 11'd5,  6, 0,  1'b0, 29'h0,    1'b0, 1'b1, 2'd1};
        vecs[5] = '{1'b1, 11'd11, 6, 0,  1'b1, 29'h1020, 1'b0, 1'b1, 2'd3};

        repeat (3) cyc();
        check("rst_ena", 160'(cmd_ena), 160'(0));
        check("rst_wena", 160'(wena), 160'(0));
        check("rst_ypos", 160'(ypos), 160'(0));
        check("rst_xpos", 160'(xpos), 160'(0));
        check("rst_addr", 160'(cmd_addr), 160'(0));
        check("rst_wr_en", 160'(write_ena), 160'(0));
        check("rst_pulses", 160'({frame_start, underrun}), 160'(0));
        reset = 1'b0;
        repeat (20) cyc();
        check("idle_no_req", 160'(acc_q.size()), 160'(0));

        for (int r = 0; r < 6; r++) begin
            ba = acc_q.size();
            bw = wr_q.size();
            lat = vecs[r].lat;
            scroll_x = vecs[r].scroll;
            if (vecs[r].yev) do_yfall(); else do_xfall();
            if (vecs[r].fetch) begin
                if (vecs[r].busy_len > 0) begin
                    k = 0;
                    while (acc_q.size() - ba < 2 && k < 100) begin cyc(); k++; end
                    busy = 1'b1;
                    held = cmd_addr;
                    stable = cmd_ena;
                    repeat (vecs[r].busy_len) begin
                        cyc();
                        if (!cmd_ena || cmd_addr !== held) stable = 1'b0;
                    end
                    busy = 1'b0;
                    check($sformatf("v%0d_busy_hold", r), 160'(stable), 160'(1));
                    check($sformatf("v%0d_busy_addr", r), 160'(held), 160'(vecs[r].addr0 + 29'd32));
                end
                wait_writes($sformatf("v%0d", r), bw, 400);
                repeat (3) cyc();
                check_fetch($sformatf("v%0d", r), ba, bw, vecs[r].addr0, vecs[r].buf_sel);
            end else begin
                repeat (40) cyc();
                check($sformatf("v%0d_no_req", r), 160'(acc_q.size() - ba), 160'(0));
            end
            check($sformatf("v%0d_ypos", r), 160'(ypos), 160'(vecs[r].ypos));
            check($sformatf("v%0d_xpos", r), 160'(xpos), 160'(vecs[r].xpos));
        end
        check("frame_starts", 160'(fs_cnt), 160'(2));
        check("no_underrun", 160'(ur_cnt), 160'(0));

        // Slow memory: second H-sync lands mid-fetch.
        lat = 40;
        ba = acc_q.size();
        bw = wr_q.size();
        do_xfall();
        repeat (10) cyc();
        do_xfall();
        cyc();
        check("ur_pulse", 160'(ur_cnt), 160'(1));
        check("ur_ypos", 160'(ypos), 160'(0));
        wait_writes("ur", bw, 400);
        repeat (3) cyc();
        check_fetch("ur", ba, bw, 29'h1120, 1'b1);
        ba = acc_q.size();
        do_xfall();
        cyc();
        check("ur_toggle", 160'(ypos), 160'(1));
        check("ur_single", 160'(ur_cnt), 160'(1));

        // Reset while the line is draining.
        k = 0;
        while (acc_q.size() - ba < HW && k < 300) begin cyc(); k++; end
        check("rst_reach_drain", 160'(acc_q.size() - ba), 160'(HW));
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        check("rst_mid_ena", 160'(cmd_ena), 160'(0));
        check("rst_mid_wena", 160'(wena), 160'(0));
        cyc();
        reset = 1'b0;
        ba = acc_q.size();
        bw = wr_q.size();
        repeat (60) cyc();
        check("rst_drop_wr", 160'(wr_q.size() - bw), 160'(0));
        check("rst_no_req", 160'(acc_q.size() - ba), 160'(0));
        check("rst_ypos0", 160'(ypos), 160'(0));

        lat = 6;
        scroll_x = 11'd0;
        ba = acc_q.size();
        bw = wr_q.size();
        do_yfall();
        wait_writes("restart", bw, 400);
        repeat (3) cyc();
        check_fetch("restart", ba, bw, 29'h1000, 1'b0);
        check("restart_ypos", 160'(ypos), 160'(1));
        check("restart_xpos", 160'(xpos), 160'(0));
        check("max_outstanding", 160'(max_out), 160'(MO));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
